// File: rtl/load_store_unit.sv
// load_store_unit
//
// Sequences byte/halfword/word loads and stores between the CPU datapath and
// a word-indexed data memory. Byte addresses are turned into word indices,
// loads are sign- or zero-extended, and sub-word stores are done as a
// read-modify-write so neighbouring bytes in the same word survive.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   Req             request valid, only looked at while idle
//   ReqWrite        1 = store, 0 = load
//   Size            00 byte, 01 halfword, 10 word, 11 reserved (faults)
//   Unsigned        1 = zero-extend loads, 0 = sign-extend
//   Addr            byte address
//   StoreData       right-aligned store data
//   Busy            high whenever a request is in progress
//   Done            one-cycle completion pulse
//   Fault           high with Done when the request was rejected
//   LoadData        extended load result, held until the next load completes
//   MemAddress      word index to memory (registered)
//   MemWriteData    full word to memory (registered)
//   MemWrite        memory write strobe (registered)
//   MemRead         memory read strobe (registered)
//   MemReadData     combinational read data from memory
module load_store_unit #(
    parameter int MAX_WORD = 3100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        ReqWrite,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    output logic        Busy,
    output logic        Done,
    output logic        Fault,
    output logic [31:0] LoadData,
    output logic [31:0] MemAddress,
    output logic [31:0] MemWriteData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] MemReadData
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WR   = 3'd2;
    localparam logic [2:0] S_RESP = 3'd3;
    localparam logic [2:0] S_FLT  = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [29:0] MAX_INDEX = 30'(MAX_WORD);

    logic [2:0]  state_q, state_d;
    logic        write_q, write_d;
    logic        unsigned_q, unsigned_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  lane_q, lane_d;
    logic [15:0] store_lo_q, store_lo_d;
    logic [31:0] line_q, line_d;
    logic [31:0] load_data_q, load_data_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;

    logic        req_fault;
    logic [31:0] merged_word;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_ext;

    // Request rejection: reserved size, misalignment, or a word index past
    // the end of the memory.
    always_comb begin
        req_fault = 1'b0;
        if (Size == 2'b11)                             req_fault = 1'b1;
        if (Size == SZ_HALF && Addr[0])                req_fault = 1'b1;
        if (Size == SZ_WORD && Addr[1:0] != 2'b00)     req_fault = 1'b1;
        if (Addr[31:2] > MAX_INDEX)                    req_fault = 1'b1;
    end

    // Merge the store lane into the word being read this cycle. It is built
    // from MemReadData rather than the line buffer so the merged word can be
    // registered at the end of RD and be stable for the whole WR cycle.
    always_comb begin
        merged_word = MemReadData;
        if (size_q == SZ_BYTE) begin
            case (lane_q)
                2'd0:    merged_word[7:0]   = store_lo_q[7:0];
                2'd1:    merged_word[15:8]  = store_lo_q[7:0];
                2'd2:    merged_word[23:16] = store_lo_q[7:0];
                default: merged_word[31:24] = store_lo_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged_word[31:16] = store_lo_q;
        end else begin
            merged_word[15:0] = store_lo_q;
        end
    end

    // Lane selection and extension of the captured line for loads.
    always_comb begin
        case (lane_q)
            2'd0:    sel_byte = line_q[7:0];
            2'd1:    sel_byte = line_q[15:8];
            2'd2:    sel_byte = line_q[23:16];
            default: sel_byte = line_q[31:24];
        endcase
        sel_half = lane_q[1] ? line_q[31:16] : line_q[15:0];
        case (size_q)
            SZ_BYTE: load_ext = {{24{~unsigned_q & sel_byte[7]}}, sel_byte};
            SZ_HALF: load_ext = {{16{~unsigned_q & sel_half[15]}}, sel_half};
            default: load_ext = line_q;
        endcase
    end

    // Next-state and datapath logic. The memory strobes, address and write
    // data are computed one state ahead so they come straight from flops.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        unsigned_d  = unsigned_q;
        size_d      = size_q;
        lane_d      = lane_q;
        store_lo_d  = store_lo_q;
        line_d      = line_q;
        load_data_d = load_data_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    write_d    = ReqWrite;
                    unsigned_d = Unsigned;
                    size_d     = Size;
                    lane_d     = Addr[1:0];
                    store_lo_d = StoreData[15:0];
                    if (req_fault) begin
                        state_d = S_FLT;
                    end else begin
                        mem_addr_d = {2'b00, Addr[31:2]};
                        if (ReqWrite && Size == SZ_WORD) begin
                            state_d     = S_WR;
                            mem_write_d = 1'b1;
                            mem_wdata_d = StoreData;
                        end else begin
                            state_d    = S_RD;
                            mem_read_d = 1'b1;
                        end
                    end
                end
            end
            S_RD: begin
                line_d = MemReadData;
                if (write_q) begin
                    state_d     = S_WR;
                    mem_write_d = 1'b1;
                    mem_wdata_d = merged_word;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_WR: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                if (!write_q) begin
                    load_data_d = load_ext;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            unsigned_q  <= 1'b0;
            size_q      <= 2'b00;
            lane_q      <= 2'b00;
            store_lo_q  <= 16'h0;
            line_q      <= 32'h0;
            load_data_q <= 32'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            unsigned_q  <= unsigned_d;
            size_q      <= size_d;
            lane_q      <= lane_d;
            store_lo_q  <= store_lo_d;
            line_q      <= line_d;
            load_data_q <= load_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    // The fresh load result is presented during RESP itself, and the
    // register holds it afterwards.
    assign LoadData     = (state_q == S_RESP && !write_q) ? load_ext : load_data_q;
    assign Busy         = (state_q != S_IDLE);
    assign Done         = (state_q == S_RESP) || (state_q == S_FLT);
    assign Fault        = (state_q == S_FLT);
    assign MemAddress   = mem_addr_q;
    assign MemWriteData = mem_wdata_q;
    assign MemRead      = mem_read_q;
    assign MemWrite     = mem_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//
// Scoreboard bench for load_store_unit. Each request pushes its expected
// strobe timing, memory traffic and completion into a queue; a negedge
// monitor follows every in-flight request cycle by cycle and pops it at Done.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Req;
    logic        ReqWrite;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] Addr;
    logic [31:0] StoreData;
    logic        Busy;
    logic        Done;
    logic        Fault;
    logic [31:0] LoadData;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] MemReadData;

    typedef struct {
        int          accept_cycle;
        int          latency;
        int          rd_phase;
        int          wr_phase;
        logic        fault;
        logic [31:0] idx;
        logic [31:0] wdata;
        logic [31:0] load_data;
    } exp_entry_t;

    exp_entry_t  score_q[$];
    logic [31:0] mem     [0:4095];
    logic [31:0] ref_mem [0:4095];
    logic [31:0] last_load;
    int          cyc_count = 0;
    int          vector_count = 0;
    int          miss_count = 0;
    bit          monitor_on = 1'b0;
    exp_entry_t  mon_entry;
    int          mon_phase;

    load_store_unit #(.MAX_WORD(3100)) dut (
        .clk          (clk),
        .reset        (reset),
        .Req          (Req),
        .ReqWrite     (ReqWrite),
        .Size         (Size),
        .Unsigned     (Unsigned),
        .Addr         (Addr),
        .StoreData    (StoreData),
        .Busy         (Busy),
        .Done         (Done),
        .Fault        (Fault),
        .LoadData     (LoadData),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .MemReadData  (MemReadData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_count <= cyc_count + 1;

    // Word-indexed memory with combinational read.
    assign MemReadData = mem[MemAddress[11:0]];
    always @(posedge clk) begin
        if (MemWrite === 1'b1) mem[MemAddress[11:0]] <= MemWriteData;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vector_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d", tag, actual, expected, cyc_count);
        end
    endtask

    // Reference behaviour of one request against the bench's shadow memory.
    task automatic predict(input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] sd, output exp_entry_t e);
        logic [31:0] word;
        logic [31:0] val;
        logic [31:0] mask;
        int          sh;
        e.accept_cycle = 0;
        e.rd_phase  = -1;
        e.wr_phase  = -1;
        e.idx       = a >> 2;
        e.wdata     = 32'h0;
        e.fault     = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
                      (sz == 2'd2 && a[1:0] != 2'd0) || ((a >> 2) > 32'd3100);
        if (e.fault) begin
            e.latency = 1;
        end else begin
            word = ref_mem[e.idx[11:0]];
            if (!w) begin
                e.latency  = 2;
                e.rd_phase = 0;
                if (sz == 2'd0) begin
                    sh  = 8 * int'(a[1:0]);
                    val = (word >> sh) & 32'hFF;
                    if (!u && val[7]) val = val | 32'hFFFF_FF00;
                end else if (sz == 2'd1) begin
                    sh  = 16 * int'(a[1]);
                    val = (word >> sh) & 32'hFFFF;
                    if (!u && val[15]) val = val | 32'hFFFF_0000;
                end else begin
                    val = word;
                end
                last_load = val;
            end else if (sz == 2'd2) begin
                e.latency  = 2;
                e.wr_phase = 0;
                e.wdata    = sd;
                ref_mem[e.idx[11:0]] = sd;
            end else begin
                e.latency  = 3;
                e.rd_phase = 0;
                e.wr_phase = 1;
                if (sz == 2'd0) begin
                    sh   = 8 * int'(a[1:0]);
                    mask = 32'hFF << sh;
                end else begin
                    sh   = 16 * int'(a[1]);
                    mask = 32'hFFFF << sh;
                end
                e.wdata = (word & ~mask) | ((sd << sh) & mask);
                ref_mem[e.idx[11:0]] = e.wdata;
            end
        end
        e.load_data = last_load;
    endtask

    // Waits for the unit to be idle, issues one request and registers its
    // expectation. Returns at the negedge after the accepting edge.
    task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic u,
                                 input logic [31:0] a, input logic [31:0] sd);
        exp_entry_t e;
        int waited = 0;
        while (Busy !== 1'b0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) checkOutput("idleWait", {31'b0, Busy}, 32'h0);
        predict(w, sz, u, a, sd, e);
        e.accept_cycle = cyc_count + 1;
        score_q.push_back(e);
        ReqWrite  = w;
        Size      = sz;
        Unsigned  = u;
        Addr      = a;
        StoreData = sd;
        Req       = 1'b1;
        @(negedge clk);
        Req = 1'b0;
    endtask

    // Cycle-by-cycle monitor of the oldest outstanding request.
    always @(negedge clk) begin
        if (monitor_on) begin
            if (score_q.size() == 0 || score_q[0].accept_cycle > cyc_count) begin
                checkOutput("noDone", {31'b0, Done}, 32'h0);
            end else begin
                mon_entry = score_q[0];
                mon_phase = cyc_count - mon_entry.accept_cycle;
                checkOutput("busy", {31'b0, Busy}, 32'h1);
                checkOutput("memRead", {31'b0, MemRead}, 32'(mon_phase == mon_entry.rd_phase));
                checkOutput("memWrite", {31'b0, MemWrite}, 32'(mon_phase == mon_entry.wr_phase));
                if (mon_phase == mon_entry.rd_phase || mon_phase == mon_entry.wr_phase)
                    checkOutput("memAddr", MemAddress, mon_entry.idx);
                if (mon_phase == mon_entry.wr_phase)
                    checkOutput("memWdata", MemWriteData, mon_entry.wdata);
                checkOutput("done", {31'b0, Done}, 32'(mon_phase == mon_entry.latency - 1));
                if (mon_phase >= mon_entry.latency - 1) begin
                    if (Done === 1'b1) begin
                        checkOutput("fault", {31'b0, Fault}, {31'b0, mon_entry.fault});
                        checkOutput("loadData", LoadData, mon_entry.load_data);
                    end
                    void'(score_q.pop_front());
                end
            end
        end
    end

    initial begin
        int waited;
        logic [1:0]  r_size;
        logic [31:0] r_addr;

        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem[4]        = 32'h8899_AABB;
        ref_mem[4]    = 32'h8899_AABB;
        mem[3100]     = 32'h1357_9BDF;
        ref_mem[3100] = 32'h1357_9BDF;
        last_load = 32'h0;

        reset = 1'b1; Req = 1'b0; ReqWrite = 1'b0; Size = 2'b00;
        Unsigned = 1'b0; Addr = 32'h0; StoreData = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("rstBusy", {31'b0, Busy}, 32'h0);
        checkOutput("rstDone", {31'b0, Done}, 32'h0);
        checkOutput("rstFault", {31'b0, Fault}, 32'h0);
        checkOutput("rstMemRead", {31'b0, MemRead}, 32'h0);
        checkOutput("rstMemWrite", {31'b0, MemWrite}, 32'h0);
        checkOutput("rstLoadData", LoadData, 32'h0);
        checkOutput("rstMemAddr", MemAddress, 32'h0);
        checkOutput("rstMemWdata", MemWriteData, 32'h0);
        reset = 1'b0;
        monitor_on = 1'b1;
        @(negedge clk);

        // Loads of word 4 in each width and extension mode.
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);

        // Halfword read-modify-write, then read the whole word back.
        applyStimulus(1'b1, 2'd1, 1'b0, 32'h12, 32'hCAFE_1234);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

        // Faults: misalignment, range edge and reserved size.
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h13, 32'h0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h3070, 32'h0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h3074, 32'h0);
        applyStimulus(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
        applyStimulus(1'b1, 2'd1, 1'b0, 32'h11, 32'h0);

        // Byte store with a second Req pulsed during RD; it must be dropped.
        applyStimulus(1'b1, 2'd0, 1'b0, 32'h10, 32'h0000_0055);
        ReqWrite = 1'b0; Size = 2'd2; Addr = 32'h3074; Req = 1'b1;
        @(negedge clk);
        Req = 1'b0;
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

        // Word store followed by byte loads of the new word.
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF_7F01);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h23, 32'h0);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h21, 32'h0);
        applyStimulus(1'b0, 2'd1, 1'b1, 32'h22, 32'h0);

        // Mixed random traffic over a few words plus out-of-range addresses.
        for (int i = 0; i < 24; i++) begin
            r_size = 2'($urandom_range(0, 3));
            r_addr = 32'($urandom_range(0, 31));
            if (i % 6 == 5) r_addr = 32'h3074 + 32'($urandom_range(0, 3));
            applyStimulus(1'($urandom_range(0, 1)), r_size, 1'($urandom_range(0, 1)),
                          r_addr, $urandom);
        end

        // Reset during WR of a byte store. The byte stored equals the byte
        // already in memory, so the word is the same whether or not it lands.
        applyStimulus(1'b1, 2'd0, 1'b0, 32'h10, ref_mem[4]);
        @(negedge clk);
        reset = 1'b1;
        score_q.delete();
        last_load = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("wrRstBusy", {31'b0, Busy}, 32'h0);
        checkOutput("wrRstMemRead", {31'b0, MemRead}, 32'h0);
        checkOutput("wrRstMemWrite", {31'b0, MemWrite}, 32'h0);
        checkOutput("wrRstLoadData", LoadData, 32'h0);
        repeat (4) @(negedge clk);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

        // Req in the same cycle as reset is dropped.
        waited = 0;
        while (Busy !== 1'b0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        reset = 1'b1; Req = 1'b1; ReqWrite = 1'b0; Size = 2'd2; Addr = 32'h10;
        last_load = 32'h0;
        @(negedge clk);
        reset = 1'b0; Req = 1'b0;
        checkOutput("rstReqBusy", {31'b0, Busy}, 32'h0);
        repeat (4) @(negedge clk);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);

        waited = 0;
        while (score_q.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("drain", 32'(score_q.size()), 32'h0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencing load/store unit between the CPU datapath and the word-indexed data memory (`Mem`). It accepts byte-addressed byte/halfword/word requests over a request/done handshake and converts byte addresses to word indices. Loads are sign- or zero-extended. Sub-word stores are performed as a read-modify-write so the word-only memory never loses neighbouring bytes.

## Interface
- `MAX_WORD`, 3100: highest legal word index of the data memory.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Req`  in  1  request valid; sampled only in IDLE.
- `ReqWrite`  in  1  1 = store, 0 = load.
- `Size`  in  2  00 byte, 01 halfword, 10 word, 11 reserved (faults).
- `Unsigned`  in  1  1 = zero-extend loads, 0 = sign-extend.
- `Addr`  in  32  byte address.
- `StoreData`  in  32  store data, right-aligned.
- `Busy`  out  1  high whenever the state is not IDLE.
- `Done`  out  1  one-cycle completion pulse.
- `Fault`  out  1  high with `Done` when the request was rejected.
- `LoadData`  out  32  extended load result; held until the next `Done`.
- `MemAddress`  out  32  word index to memory (`Addr >> 2`).
- `MemWriteData`  out  32  full word to memory.
- `MemWrite`  out  1  memory write strobe.
- `MemRead`  out  1  memory read strobe.
- `MemReadData`  in  32  combinational read data from memory.

## Operation
- States: IDLE, RD, WR, RESP, FLT.
- IDLE: if `Req`, latch `Addr`, `Size`, `ReqWrite`, `Unsigned` and `StoreData`, then run the fault check:
  - `Size`=11;
  - halfword with `Addr[0]`=1;
  - word with `Addr[1:0]`≠0;
  - `Addr[31:2]` > `MAX_WORD`.
- IDLE next state:
  - any fault → FLT;
  - word store → WR;
  - load or sub-word store → RD.
- RD: `MemRead`=1. Capture `MemReadData` into the line buffer at the cycle end. Next state: load → RESP; sub-word store → WR.
- WR: `MemWrite`=1. `MemWriteData` is one of:
  - word store: `StoreData`;
  - byte store: line buffer with lane `Addr[1:0]` (bits 8k+7:8k) replaced by `StoreData[7:0]`;
  - halfword store: lane `Addr[1]` (bits 16h+15:16h) replaced by `StoreData[15:0]`.
- WR always goes to RESP.
- Lane order is little-endian.
- RESP: `Done`=1, `Fault`=0. For loads, `LoadData` is updated this cycle with the selected lane, extended per `Unsigned`. For stores, `LoadData` is unchanged. Next state IDLE.
- FLT: `Done`=1 and `Fault`=1. No memory strobe in this state or any state of the request. `LoadData` is unchanged. Next state IDLE.
- `Req` while `Busy` is ignored; it is not queued.
- `MemRead` and `MemWrite` are never high together.

## Timing
- Request accepted at edge t (IDLE, `Req`=1). `Done` pulse occurs at:
  - load: t+2;
  - word store: t+2;
  - sub-word store: t+3;
  - fault: t+1.
- Back-to-back: a new `Req` is accepted in the IDLE cycle following RESP/FLT, so throughput is at most one request per 3 cycles.
- `MemAddress`, `MemWriteData`, `MemRead` and `MemWrite` are driven directly from flops.
  - This is required because downstream memory writes combinationally while `MemWrite` is high.
  - The address and data must therefore be stable for the whole WR cycle.
- `MemAddress` holds its last value outside RD/WR.
- Reset values: state IDLE; `Busy`, `Done`, `Fault`, `MemRead`, `MemWrite` = 0; `LoadData`, `MemAddress`, `MemWriteData`, line buffer = 0.
- Reset mid-operation: state is IDLE and all strobes are 0 at the next edge, and the pending `Done` is never issued. A reset that arrives during WR may still let that single write land; this is acceptable.
- `Req` high in the same cycle as `reset`: `reset` wins and the request is dropped.

## Test plan
- Memory word 4 = 0x8899AABB; load word, `Addr`=0x10 → `MemRead` at t+1 with `MemAddress`=4; `Done` at t+2; `LoadData`=0x8899AABB, `Fault`=0.
- Byte load `Addr`=0x11, `Unsigned`=0 → `LoadData`=0xFFFFFFAA. Repeat with `Unsigned`=1 → 0x000000AA. Halfword load `Addr`=0x12, signed → 0xFFFF8899.
- Halfword store `Addr`=0x12, `StoreData`=0xCAFE1234 → RD at t+1, WR at t+2 with `MemWriteData`=0x1234AABB, `Done` at t+3. A following word load of 0x10 returns 0x1234AABB.
- Misaligned word load `Addr`=0x13 → `Done`=`Fault`=1 at t+1; `MemRead`/`MemWrite` never asserted; `LoadData` unchanged.
- Range: word load `Addr`=0x3070 (index 3100) → normal; `Addr`=0x3074 (index 3101) → `Fault` at t+1. `Size`=11 at any address also → `Fault`.
- Byte store `Addr`=0x10: pulse `Req` again during RD → ignored, only one `Done`. In a second run, assert `reset` during WR → next cycle `Busy`=0 and all strobes 0; no `Done` ever appears.
